// File: rtl/color_stabilizer_pkg.sv
// Shared color definitions for the color path (interpretation -> stabilizer -> Core).
package color_stabilizer_pkg;

  // 2-bit color code as produced by the interpretation stage
  typedef logic [1:0] color_t;

  localparam color_t COLOR_NONE  = 2'd0;
  localparam color_t COLOR_RED   = 2'd1;
  localparam color_t COLOR_GREEN = 2'd2;
  localparam color_t COLOR_BLUE  = 2'd3;

  // Channel indices inside the stabilizer (object, station)
  localparam int NUM_CH = 2;
  localparam int CH_OBJ = 0;
  localparam int CH_STA = 1;

  // Pending-event record handed to Core
  typedef struct packed {
    logic   valid;
    color_t color;
  } evt_t;

  // True for any real color (everything except "none")
  function automatic logic is_color(input color_t c);
    return c != COLOR_NONE;
  endfunction

endpackage

// File: rtl/color_debounce.sv
// One color channel: debounce a raw 2-bit code, hold the stable value, and
// present non-zero transitions as a valid/ack event.
// Optional macro COLOR_OVERRUN_EN builds a sticky overrun flag.
module color_debounce
  import color_stabilizer_pkg::*;
#(
  parameter int STABLE_US = 24000
) (
  input  logic   clkus,
  input  logic   rst_n,
  input  color_t i_raw,
  input  logic   i_ack,
  output color_t o_stable,
  output evt_t   o_evt,
  output logic   o_overrun
);

  localparam int               CNT_W   = (STABLE_US > 1) ? $clog2(STABLE_US) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_US - 1);

  color_t           r_cand;
  logic [CNT_W-1:0] r_cnt;
  color_t           r_stable;
  evt_t             r_evt;

  logic w_same;
  logic w_settled;
  logic w_commit;
  logic w_new_evt;
  logic w_ack;

  // Candidate has been held long enough and differs from what is committed
  assign w_same    = (i_raw == r_cand);
  assign w_settled = w_same && (r_cnt == CNT_MAX);
  assign w_commit  = w_settled && (r_stable != r_cand);
  assign w_new_evt = w_commit && is_color(r_cand);
  assign w_ack     = r_evt.valid && i_ack;

  // Track the candidate code and how long it has been held (saturating)
  always_ff @(posedge clkus or negedge rst_n) begin
    if (!rst_n) begin
      r_cand <= COLOR_NONE;
      r_cnt  <= '0;
    end else if (!w_same) begin
      r_cand <= i_raw;
      r_cnt  <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  // Commit the candidate as the stable color
  always_ff @(posedge clkus or negedge rst_n) begin
    if (!rst_n)        r_stable <= COLOR_NONE;
    else if (w_commit) r_stable <= r_cand;
  end

  // Event handshake: a new commit beats a same-edge ack
  always_ff @(posedge clkus or negedge rst_n) begin
    if (!rst_n) begin
      r_evt <= '0;
    end else if (w_new_evt) begin
      r_evt.valid <= 1'b1;
      r_evt.color <= r_cand;
    end else if (w_ack) begin
      r_evt.valid <= 1'b0;
    end
  end

`ifdef COLOR_OVERRUN_EN
  logic r_overrun;

  // Sticky: a pending event was replaced without Core having taken it
  always_ff @(posedge clkus or negedge rst_n) begin
    if (!rst_n)                                     r_overrun <= 1'b0;
    else if (w_new_evt && r_evt.valid && !i_ack)    r_overrun <= 1'b1;
  end

  assign o_overrun = r_overrun;
`else
  assign o_overrun = 1'b0;
`endif

  assign o_stable = r_stable;
  assign o_evt    = r_evt;

endmodule

// File: rtl/color_stabilizer.sv
// Debounces the object and station color codes and turns committed non-zero
// colors into valid/ack events for Core. All outputs are registered.
// Optional macro COLOR_OVERRUN_EN enables the sticky overrun flags.
module color_stabilizer
  import color_stabilizer_pkg::*;
#(
  parameter int STABLE_US = 24000
) (
  input  logic       clkus,
  input  logic       rst_n,
  input  logic [1:0] object_color,
  input  logic [1:0] station_color,
  output logic [1:0] object_color_stable,
  output logic [1:0] station_color_stable,
  output logic       object_evt_valid,
  output logic [1:0] object_evt_color,
  input  logic       object_evt_ack,
  output logic       station_evt_valid,
  output logic [1:0] station_evt_color,
  input  logic       station_evt_ack,
  output logic       object_overrun,
  output logic       station_overrun
);

  color_t [NUM_CH-1:0] w_raw;
  color_t [NUM_CH-1:0] w_stable;
  evt_t   [NUM_CH-1:0] w_evt;
  logic   [NUM_CH-1:0] w_ack;
  logic   [NUM_CH-1:0] w_ovr;

  // Gather per-channel inputs into lane arrays
  always_comb begin
    w_raw         = '0;
    w_ack         = '0;
    w_raw[CH_OBJ] = object_color;
    w_raw[CH_STA] = station_color;
    w_ack[CH_OBJ] = object_evt_ack;
    w_ack[CH_STA] = station_evt_ack;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    color_debounce #(
      .STABLE_US (STABLE_US)
    ) u_deb (
      .clkus     (clkus),
      .rst_n     (rst_n),
      .i_raw     (w_raw[g]),
      .i_ack     (w_ack[g]),
      .o_stable  (w_stable[g]),
      .o_evt     (w_evt[g]),
      .o_overrun (w_ovr[g])
    );
  end

  assign object_color_stable  = w_stable[CH_OBJ];
  assign object_evt_valid     = w_evt[CH_OBJ].valid;
  assign object_evt_color     = w_evt[CH_OBJ].color;
  assign object_overrun       = w_ovr[CH_OBJ];

  assign station_color_stable = w_stable[CH_STA];
  assign station_evt_valid    = w_evt[CH_STA].valid;
  assign station_evt_color    = w_evt[CH_STA].color;
  assign station_overrun      = w_ovr[CH_STA];

endmodule

// File: tb/tb_color_stabilizer.sv
// Bench for color_stabilizer with STABLE_US=4: a table of per-cycle vectors
// checked through a scoreboard queue, plus hand-written reset sequences.
module tb_color_stabilizer;

`ifdef COLOR_OVERRUN_EN
  localparam logic OVR = 1'b1;
`else
  localparam logic OVR = 1'b0;
`endif

  logic       clkus = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] object_color = '0, station_color = '0;
  logic       object_evt_ack = 1'b0, station_evt_ack = 1'b0;
  logic [1:0] object_color_stable, station_color_stable;
  logic       object_evt_valid, station_evt_valid;
  logic [1:0] object_evt_color, station_evt_color;
  logic       object_overrun, station_overrun;

  color_stabilizer #(.STABLE_US(4)) dut (
    .clkus                (clkus),
    .rst_n                (rst_n),
    .object_color         (object_color),
    .station_color        (station_color),
    .object_color_stable  (object_color_stable),
    .station_color_stable (station_color_stable),
    .object_evt_valid     (object_evt_valid),
    .object_evt_color     (object_evt_color),
    .object_evt_ack       (object_evt_ack),
    .station_evt_valid    (station_evt_valid),
    .station_evt_color    (station_evt_color),
    .station_evt_ack      (station_evt_ack),
    .object_overrun       (object_overrun),
    .station_overrun      (station_overrun)
  );

  always #5 clkus = ~clkus;

  typedef struct packed {
    logic [1:0] os; logic ov; logic [1:0] oc; logic oo;
    logic [1:0] ss; logic sv; logic [1:0] sc; logic so;
  } exp_t;

  typedef struct {
    logic [1:0] oraw; logic [1:0] sraw; logic oack; logic sack;
    exp_t       e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input int n, input logic [1:0] oraw, input logic [1:0] sraw,
                     input logic oack, input logic sack,
                     input logic [1:0] os, input logic ov, input logic [1:0] oc, input logic oo,
                     input logic [1:0] ss, input logic sv, input logic [1:0] sc);
    vec_t v;
    v.oraw = oraw; v.sraw = sraw; v.oack = oack; v.sack = sack;
    v.e = '{os:os, ov:ov, oc:oc, oo:oo, ss:ss, sv:sv, sc:sc, so:1'b0};
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %0d expected %0d", nm, idx, got, exp);
    end
  endtask

  function automatic exp_t sample();
    exp_t s;
    s = '{os:object_color_stable, ov:object_evt_valid, oc:object_evt_color, oo:object_overrun,
          ss:station_color_stable, sv:station_evt_valid, sc:station_evt_color, so:station_overrun};
    return s;
  endfunction

  task automatic chk_all(input string tag, input int idx, input exp_t e);
    exp_t g;
    g = sample();
    chk({tag, ".obj_stable"},  idx, g.os, e.os);
    chk({tag, ".obj_valid"},   idx, {1'b0, g.ov}, {1'b0, e.ov});
    chk({tag, ".obj_color"},   idx, g.oc, e.oc);
    chk({tag, ".obj_overrun"}, idx, {1'b0, g.oo}, {1'b0, e.oo});
    chk({tag, ".sta_stable"},  idx, g.ss, e.ss);
    chk({tag, ".sta_valid"},   idx, {1'b0, g.sv}, {1'b0, e.sv});
    chk({tag, ".sta_color"},   idx, g.sc, e.sc);
    chk({tag, ".sta_overrun"}, idx, {1'b0, g.so}, {1'b0, e.so});
  endtask

  initial begin
    exp_t z;
    exp_t e;
    z = '0;

    //  n  oraw sraw oa sa | os ov oc oo   | ss sv sc
    add(4, 2, 3, 0, 0,  0, 0, 0, 0,    0, 0, 0);  // first commit pending
    add(1, 2, 3, 0, 0,  2, 1, 2, 0,    3, 1, 3);  // 4 edges after first sample
    add(1, 2, 3, 1, 1,  2, 0, 2, 0,    3, 0, 3);  // ack both
    add(4, 1, 3, 0, 0,  2, 0, 2, 0,    3, 0, 3);
    add(1, 1, 3, 0, 0,  1, 1, 1, 0,    3, 0, 3);  // stable = 1
    add(1, 1, 3, 1, 0,  1, 0, 1, 0,    3, 0, 3);
    add(1, 3, 3, 0, 0,  1, 0, 1, 0,    3, 0, 3);  // 3-clock glitch to 3
    add(1, 3, 3, 1, 0,  1, 0, 1, 0,    3, 0, 3);  // ack while idle ignored
    add(1, 3, 3, 0, 0,  1, 0, 1, 0,    3, 0, 3);
    add(5, 1, 3, 0, 0,  1, 0, 1, 0,    3, 0, 3);  // back to stable: no event
    add(4, 3, 3, 0, 0,  1, 0, 1, 0,    3, 0, 3);
    add(1, 3, 3, 0, 0,  3, 1, 3, 0,    3, 0, 3);  // event 3
    add(10,3, 3, 0, 0,  3, 1, 3, 0,    3, 0, 3);  // held without ack
    add(1, 3, 3, 1, 0,  3, 0, 3, 0,    3, 0, 3);  // ack drops valid
    add(4, 1, 3, 0, 0,  3, 0, 3, 0,    3, 0, 3);
    add(1, 1, 3, 0, 0,  1, 1, 1, 0,    3, 0, 3);  // event 1 left pending
    add(4, 3, 3, 0, 0,  1, 1, 1, 0,    3, 0, 3);
    add(1, 3, 3, 1, 0,  3, 1, 3, 0,    3, 0, 3);  // ack on commit edge
    add(4, 2, 3, 0, 0,  3, 1, 3, 0,    3, 0, 3);
    add(1, 2, 3, 0, 0,  2, 1, 2, OVR,  3, 0, 3);  // overwrite unacked
    add(1, 2, 3, 1, 0,  2, 0, 2, OVR,  3, 0, 3);
    add(4, 2, 0, 0, 0,  2, 0, 2, OVR,  3, 0, 3);  // station -> none
    add(3, 2, 0, 0, 0,  2, 0, 2, OVR,  0, 0, 3);  // none commit, no event

    // Reset held with raw codes present: outputs stay zero
    object_color = 2'd2; station_color = 2'd3;
    repeat (3) @(posedge clkus);
    #1 chk_all("reset", 0, z);
    @(negedge clkus);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      object_color    = tbl[i].oraw;
      station_color   = tbl[i].sraw;
      object_evt_ack  = tbl[i].oack;
      station_evt_ack = tbl[i].sack;
      sb.push_back(tbl[i].e);
      @(posedge clkus);
      #1;
      e = sb.pop_front();
      chk_all("tbl", i, e);
      @(negedge clkus);
    end

    // Reset asserted mid-count with overrun possibly set: clears at once
    object_color = 2'd1; object_evt_ack = 1'b0; station_evt_ack = 1'b0;
    repeat (2) @(posedge clkus);
    @(negedge clkus);
    rst_n = 1'b0;
    #1 chk_all("midrst", 0, z);
    @(negedge clkus);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clkus);
      #1;
      e = z;
      if (k == 5) begin e.os = 2'd1; e.ov = 1'b1; e.oc = 2'd1; end
      chk_all("restart", k, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/color_stabilizer.md
# color_stabilizer

Debounces and event-izes the 2-bit color codes produced by the color interpretation stage (object and station sensors) before they reach Core. Each channel must hold a code unchanged for `STABLE_US` microseconds before it becomes the stable color. A transition to a non-zero color raises a valid/ack event for Core. Sits between the color interpretation block and Core, clocked on the 1 MHz `clkus` domain.

## Interface
- `STABLE_US`, default 24000: clocks a raw code must stay constant before it is committed (24 ms = 3 full R/G/B/CALC rounds); legal range 2..32767.
- `clkus` in 1: 1 MHz system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `object_color` in 2: raw object code (0 none, 1 red, 2 green, 3 blue).
- `station_color` in 2: raw station code, same encoding.
- `object_color_stable` out 2: debounced object code.
- `station_color_stable` out 2: debounced station code.
- `object_evt_valid` out 1: an object color event is pending.
- `object_evt_color` out 2: color of the pending object event.
- `object_evt_ack` in 1: Core consumes the object event.
- `station_evt_valid`, `station_evt_color`, `station_evt_ack`: same three signals for the station channel.
- `object_overrun` out 1: sticky flag, object event overwritten before ack.
- `station_overrun` out 1: sticky flag, station event overwritten before ack.

## Operation
- The two channels are identical and independent. Per-channel registers:
  - `cand` (2 bits)
  - `cnt` (width `$clog2(STABLE_US)`)
  - `stable` (2 bits)
  - `evt_valid` (1 bit)
  - `evt_color` (2 bits)
  - `overrun` (1 bit)
- Reset: every register is 0. All outputs are 0 and stable color reads "none".
- Each edge, if `raw != cand`: `cand <= raw`, `cnt <= 0`.
- Else, if `cnt != STABLE_US-1`: `cnt <= cnt+1`. Otherwise `cnt` saturates at `STABLE_US-1`.
- Commit condition: `raw == cand && cnt == STABLE_US-1 && stable != cand`. On commit, `stable <= cand`.
- Commit with `cand != 0`:
  - `evt_valid <= 1`, `evt_color <= cand`.
  - If `evt_valid` was already 1 and ack is not asserted in the same cycle, the older event is lost and `overrun <= 1` (only when the feature is enabled, see Configuration).
- Commit with `cand == 0`: updates `stable` only; no event.
- Ack: when `evt_valid && ack` are both high on an edge, `evt_valid <= 0` on that edge, unless a commit happens on the same edge.
- Ack with `evt_valid == 0` is ignored.
- Simultaneous ack and commit: the new event wins. `evt_valid` stays 1, `evt_color` takes the new value, and no overrun is flagged.
- A raw glitch shorter than `STABLE_US` clocks restarts `cnt` and never reaches `stable`.
- Returning to the already-stable code never creates an event.

## Timing
- Raw code first sampled different at edge E0:
  - `cand`/`cnt` reload at E0.
  - `stable` and `evt_valid` update at edge E0+`STABLE_US`.
  - Latency is exactly `STABLE_US` clocks.
- `evt_valid` is held until acked. `evt_color` is constant while `evt_valid` is high, except when overwritten by a newer commit.
- Ack is sampled; `evt_valid` falls on the same edge that samples ack high.
- Back-to-back events on one channel are at least `STABLE_US` clocks apart.
- All outputs are registered; there are no combinational paths from input to output.
- Reset asserted mid-count or with an event pending: everything clears immediately. Counting restarts from the first edge after deassertion.

## Configuration
- `COLOR_OVERRUN_EN` defined: `overrun` logic is present and sets as described. It is sticky and cleared only by `rst_n`.
- Not defined: `object_overrun` and `station_overrun` are tied to 0 and the overrun registers are not built. Event behaviour is otherwise identical (overwrite still occurs).

## Structure
- A shared package holds:
  - Color code constants `COLOR_NONE=0`, `COLOR_RED=1`, `COLOR_GREEN=2`, `COLOR_BLUE=3`.
  - A `color_t` 2-bit typedef, shared with the color interpretation block and Core.
- Sub-module `color_debounce`: one channel (raw, stable, evt handshake, overrun), parameterized by `STABLE_US`. The top instantiates it twice (object, station).

## Test plan
All scenarios use `STABLE_US=4`.
- Reset: hold `rst_n=0` with raw=2 -> all outputs 0. Release, raw=2 held -> `object_color_stable=2` and `object_evt_valid=1`/`evt_color=2` exactly 4 edges after the first sampling edge.
- Glitch rejection: stable=1, raw pulses 3 for 3 clocks then back to 1 -> `stable` stays 1, no event.
- Handshake: event color 3 pending, ack held low for 10 clocks -> valid stays 1. Ack high 1 clock -> valid 0 next edge. Ack while valid=0 -> no effect.
- Overwrite: event 1 pending unacked, raw changes to 2 and holds 4 clocks -> `evt_color=2`, valid 1. `overrun=1` with `COLOR_OVERRUN_EN`, 0 without.
- Simultaneous: ack asserted on the exact commit edge of a new color 3 -> valid stays 1, `evt_color=3`, `overrun=0`.
- Channel independence and none-commit: station raw goes 3 -> 0 held 4 clocks -> `station_color_stable=0`, no station event, object outputs unchanged.
